// File: rtl/grid_feeder.sv
// grid_feeder: debounced button front end that loads grid rows into a FIFO and streams them to a grid engine
module grid_feeder #(
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                     clock,
    input  logic                     clear_n,
    input  logic                     btn_load,
    input  logic                     btn_start,
    input  logic [15:0]              gpio_beam,
    input  logic [15:0]              gpio_grid,
    input  logic                     grid_ready,
    output logic                     start,
    output logic [15:0]              beam_in,
    output logic [15:0]              grid_in,
    output logic                     grid_valid,
    output logic                     busy,
    output logic                     feed_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, FINISH} state_t;
    state_t          state_q, state_d;
    logic [1:0]      btn_m_q, btn_s_q;
    logic [15:0]     beam_m_q, beam_s_q, grid_m_q, grid_s_q;
    logic            lvl_q  [2];
    logic            prev_q [2];
    logic [CW-1:0]   cnt_q  [2];
    logic [15:0]     mem_q  [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q;
    logic            overflow_q;
    logic [15:0]     beam_q;
    logic            load_pulse, start_pulse, idle, push, pop, go;
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            btn_m_q  <= '0;
            btn_s_q  <= '0;
            beam_m_q <= '0;
            beam_s_q <= '0;
            grid_m_q <= '0;
            grid_s_q <= '0;
        end else begin
            btn_m_q  <= {btn_start, btn_load};
            btn_s_q  <= btn_m_q;
            beam_m_q <= gpio_beam;
            beam_s_q <= beam_m_q;
            grid_m_q <= gpio_grid;
            grid_s_q <= grid_m_q;
        end
    end
    // index 0 is the load button, index 1 the start button
    always_ff @(posedge clock) begin
        for (int b = 0; b < 2; b++) begin
            if (!clear_n) begin
                cnt_q[b]  <= '0;
                lvl_q[b]  <= 1'b0;
                prev_q[b] <= 1'b0;
            end else begin
                prev_q[b] <= lvl_q[b];
                if (btn_s_q[b] == lvl_q[b]) cnt_q[b] <= '0;
                else if (cnt_q[b] == LAST) begin
                    cnt_q[b] <= '0;
                    lvl_q[b] <= btn_s_q[b];
                end else cnt_q[b] <= cnt_q[b] + 1'b1;
            end
        end
    end
    assign load_pulse  = lvl_q[0] & ~prev_q[0];
    assign start_pulse = lvl_q[1] & ~prev_q[1];
    assign idle        = state_q == IDLE;
    assign push        = idle & load_pulse & (count_q != FULL);
    assign pop         = grid_valid & grid_ready;
    assign go          = idle & start_pulse & (count_q != '0);
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= grid_s_q;
    end
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            beam_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= push ? wr_q + 1'b1 : wr_q;
            rd_q       <= pop ? rd_q + 1'b1 : rd_q;
            count_q    <= push ? count_q + 1'b1 : (pop ? count_q - 1'b1 : count_q);
            overflow_q <= overflow_q | (idle & load_pulse & (count_q == FULL));
            beam_q     <= go ? beam_s_q : beam_q;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = go ? LAUNCH : IDLE;
            LAUNCH:  state_d = STREAM;
            STREAM:  state_d = (pop && count_q == (AW + 1)'(1)) ? FINISH : STREAM;
            FINISH:  state_d = IDLE;
        endcase
    end
    always_comb begin
        start      = state_q == LAUNCH;
        busy       = state_q != IDLE;
        feed_done  = state_q == FINISH;
        grid_valid = (state_q == STREAM) && (count_q != '0);
        grid_in    = grid_valid ? mem_q[rd_q] : '0;
    end
    assign beam_in    = beam_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_grid_feeder.sv
// tb_grid_feeder: directed and randomized checks of grid_feeder against a queue-based model
module tb_grid_feeder;
    logic        clock = 1'b0, clear_n = 1'b0, btn_load = 1'b0, btn_start = 1'b0, grid_ready = 1'b0;
    logic [15:0] gpio_beam = '0, gpio_grid = '0;
    logic        start, grid_valid, busy, feed_done, overflow;
    logic [15:0] beam_in, grid_in;
    logic [4:0]  fifo_count;
    int          checks = 0, passed = 0, failed = 0;
    logic [15:0] q[$];
    logic        ovf_m = 1'b0;
    logic [15:0] beam_m = '0;

    grid_feeder #(.DEPTH(16), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .clear_n(clear_n), .btn_load(btn_load), .btn_start(btn_start),
        .gpio_beam(gpio_beam), .gpio_grid(gpio_grid), .grid_ready(grid_ready),
        .start(start), .beam_in(beam_in), .grid_in(grid_in), .grid_valid(grid_valid),
        .busy(busy), .feed_done(feed_done), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic idle_chk(input string t);
        chk({t, ".count"}, 32'(fifo_count), q.size());
        chk({t, ".overflow"}, 32'(overflow), 32'(ovf_m));
        chk({t, ".busy"}, 32'(busy), 0);
        chk({t, ".start"}, 32'(start), 0);
        chk({t, ".valid"}, 32'(grid_valid), 0);
        chk({t, ".feed_done"}, 32'(feed_done), 0);
        chk({t, ".grid_in"}, 32'(grid_in), 0);
        chk({t, ".beam_in"}, 32'(beam_in), 32'(beam_m));
    endtask

    task automatic do_reset(input string t);
        clear_n = 1'b0;
        cyc(1);
        q.delete();
        ovf_m  = 1'b0;
        beam_m = '0;
        idle_chk(t);
        clear_n = 1'b1;
    endtask

    task automatic load(input logic [15:0] d);
        gpio_grid = d;
        cyc(1);
        btn_load = 1'b1;
        cyc(10);
        btn_load = 1'b0;
        cyc(10);
        if (q.size() < 16) q.push_back(d);
        else ovf_m = 1'b1;
        idle_chk("load");
    endtask

    // mode 0: always ready, 1: stall 5 cycles on row 00B2, 2: random ready
    task automatic run(input int mode, input logic [15:0] beam);
        int k = 0, stalls = 0, budget = 300;
        logic r;
        gpio_beam = beam;
        cyc(1);
        btn_start = 1'b1;
        while (start !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        chk("start_seen", 32'(start), 1);
        beam_m = beam;
        chk("launch.beam_in", 32'(beam_in), 32'(beam_m));
        chk("launch.busy", 32'(busy), 1);
        chk("launch.valid", 32'(grid_valid), 0);
        cyc(1);
        chk("start_one_cycle", 32'(start), 0);
        chk("latency.valid", 32'(grid_valid), 1);
        while (q.size() > 0 && budget > 0) begin
            chk("stream.valid", 32'(grid_valid), 1);
            chk("stream.grid_in", 32'(grid_in), 32'(q[0]));
            chk("stream.busy", 32'(busy), 1);
            chk("stream.feed_done", 32'(feed_done), 0);
            if (mode == 0) r = 1'b1;
            else if (mode == 1) begin
                r = !(q[0] == 16'h00B2 && stalls < 5);
                if (!r) stalls++;
            end else r = 1'($urandom_range(0, 1));
            grid_ready = r;
            cyc(1);
            if (r) void'(q.pop_front());
            budget--;
        end
        grid_ready = 1'b0;
        chk("finish.valid", 32'(grid_valid), 0);
        chk("finish.feed_done", 32'(feed_done), 1);
        chk("finish.count", 32'(fifo_count), 0);
        cyc(1);
        chk("after.feed_done", 32'(feed_done), 0);
        chk("after.busy", 32'(busy), 0);
        btn_start = 1'b0;
        cyc(10);
        idle_chk("run_end");
    endtask

    initial begin
        cyc(2);
        do_reset("reset");
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            cyc(2);
        end
        btn_load = 1'b0;
        cyc(10);
        idle_chk("bounce");
        load(16'h0003);
        do_reset("reset2");
        load(16'h00A1);
        load(16'h00B2);
        load(16'h00C3);
        run(0, 16'h0100);
        load(16'h00A1);
        load(16'h00B2);
        load(16'h00C3);
        run(1, 16'h0100);
        for (int n = 0; n < 4; n++) begin
            int rows = $urandom_range(1, 6);
            for (int i = 0; i < rows; i++) load(16'($urandom));
            run(2, 16'($urandom));
        end
        for (int i = 0; i < 17; i++) load(16'($urandom));
        chk("full.count", 32'(fifo_count), 16);
        chk("full.overflow", 32'(overflow), 1);
        run(2, 16'($urandom));
        btn_start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            chk("empty_start.start", 32'(start), 0);
            chk("empty_start.busy", 32'(busy), 0);
        end
        btn_start = 1'b0;
        cyc(10);
        for (int i = 0; i < 4; i++) load(16'($urandom));
        gpio_beam = 16'($urandom);
        btn_start = 1'b1;
        for (int k = 0; k < 20 && start !== 1'b1; k++) cyc(1);
        chk("abort.start", 32'(start), 1);
        cyc(1);
        grid_ready = 1'b1;
        cyc(2);
        void'(q.pop_front());
        void'(q.pop_front());
        chk("abort.grid_in", 32'(grid_in), 32'(q[0]));
        clear_n = 1'b0;
        grid_ready = 1'b0;
        cyc(1);
        clear_n = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        beam_m = '0;
        chk("abort.busy", 32'(busy), 0);
        chk("abort.count", 32'(fifo_count), 0);
        chk("abort.valid", 32'(grid_valid), 0);
        chk("abort.feed_done", 32'(feed_done), 0);
        btn_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("abort.no_feed_done", 32'(feed_done), 0);
        end
        idle_chk("abort_end");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/grid_feeder.md
GRID_FEEDER -- requirements
Module: grid_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning row FIFO capacity (power of 2, 2..64).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the stable-sample count for a button (10 ms at 25 MHz).
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port clear_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port btn_load, input, 1, raw asynchronous button that pushes gpio_grid into the FIFO.
REQ-006 SHALL have port btn_start, input, 1, raw asynchronous button that launches a run.
REQ-007 SHALL have port gpio_beam, input, 16, raw asynchronous beam pattern.
REQ-008 SHALL have port gpio_grid, input, 16, raw asynchronous grid row.
REQ-009 SHALL have port grid_ready, input, 1, downstream engine accepts grid_in this cycle.
REQ-010 SHALL have port start, output, 1, one-cycle run-start pulse to the engine.
REQ-011 SHALL have port beam_in, output, 16, beam pattern latched at run start.
REQ-012 SHALL have port grid_in, output, 16, FIFO head row; 0 when grid_valid=0.
REQ-013 SHALL have port grid_valid, output, 1, grid_in holds a valid row.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port feed_done, output, 1, one-cycle pulse after the last row is consumed.
REQ-016 SHALL have port fifo_count, output, clog2(DEPTH)+1, rows currently stored.
REQ-017 SHALL have port overflow, output, 1, sticky flag: a load was attempted while the FIFO was full.

Function
REQ-018 SHALL pass btn_load, btn_start, gpio_beam and gpio_grid each through a 2-flop synchronizer before any use.
REQ-019 SHALL debounce each synchronized button: its debounced level changes only after the raw sample differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the counter.
REQ-020 SHALL produce a one-cycle load_pulse or start_pulse on each 0->1 transition of a debounced level; holding a button produces no further pulses.
REQ-021 SHALL, on load_pulse in IDLE with fifo_count<DEPTH, push the synchronized gpio_grid and increment fifo_count on the next edge.
REQ-022 SHALL, on load_pulse in IDLE with fifo_count==DEPTH, discard the row and set overflow; overflow clears only on reset.
REQ-023 SHALL ignore load_pulse in any non-IDLE state, with no push and no overflow.
REQ-024 SHALL implement the FSM IDLE -> LAUNCH -> STREAM -> FINISH -> IDLE.
REQ-025 SHALL, in IDLE with start_pulse and fifo_count>0, register the synchronized gpio_beam into beam_in and enter LAUNCH; start_pulse with fifo_count==0 is ignored.
REQ-026 SHALL, in LAUNCH, assert start for exactly one cycle, then enter STREAM.
REQ-027 SHALL, in STREAM, assert grid_valid while fifo_count>0, with grid_in equal to the FIFO head.
REQ-028 SHALL pop the FIFO head on every cycle with grid_valid and grid_ready both high; back-to-back pops are allowed.
REQ-029 SHALL hold grid_in and grid_valid stable while grid_valid=1 and grid_ready=0.
REQ-030 SHALL, on the pop that empties the FIFO, enter FINISH; FINISH asserts feed_done for one cycle and then returns to IDLE.
REQ-031 SHALL hold beam_in from LAUNCH until the next LAUNCH.
REQ-032 SHALL ignore start_pulse outside IDLE.
REQ-033 SHALL preserve order and allow no push/pop in the same cycle; fifo_count never exceeds DEPTH or underflows.
REQ-034 SHALL deliver rows in FIFO order: the first loaded row is the first presented.
REQ-035 SHALL have latency: start_pulse cycle N -> start high at N+1 -> grid_valid first high at N+2.

Reset
REQ-036 SHALL, while clear_n=0 at a clock edge, reset to IDLE with start=0, beam_in=0, grid_in=0, grid_valid=0, busy=0, feed_done=0, fifo_count=0, overflow=0, all debounced levels=0 and all debounce counters=0.
REQ-037 SHALL make reset asserted mid-STREAM flush all stored rows, with no feed_done pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 SHALL cover: gpio_grid=16'h0003, btn_load held 10 cycles -> exactly one push, fifo_count=1.
REQ-039 SHALL cover: btn_load toggled every 2 cycles for 20 cycles -> no push, fifo_count=0.
REQ-040 SHALL cover: load rows A1,B2,C3, gpio_beam=16'h0100, press start, grid_ready=1 -> start one cycle, then grid_in A1,B2,C3 on consecutive cycles, feed_done one cycle later, fifo_count=0, beam_in=16'h0100.
REQ-041 SHALL cover: same run with grid_ready=0 for 5 cycles mid-stream -> grid_in held at B2 for those cycles, no loss, no duplicate.
REQ-042 SHALL cover: 17 loads at DEPTH=16 -> fifo_count=16, overflow=1; press start with an empty FIFO -> no start pulse, busy=0.
REQ-043 SHALL cover: clear_n=0 one cycle during STREAM with 2 rows left -> next cycle busy=0, fifo_count=0, grid_valid=0, no feed_done.
